// File: rtl/branch_resolver.sv
// Branch resolution queue: holds in-flight predictions in order, compares each
// against the resolved outcome, and produces redirect/flush and statistics.
module branch_resolver #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 32
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     pred_valid_i,
   output logic                     pred_ready_o,
   input  logic [31:0]              pred_pc_i,
   input  logic                     pred_taken_i,
   input  logic [31:0]              pred_target_i,
   input  logic                     res_valid_i,
   input  logic                     res_taken_i,
   input  logic [31:0]              res_target_i,
   output logic                     mispredict_o,
   output logic [31:0]              redirect_pc_o,
   output logic                     res_error_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic [CNT_W-1:0]         branch_cnt_o,
   output logic [CNT_W-1:0]         miss_cnt_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [31:0]      pc_mem     [DEPTH];
   logic             taken_mem  [DEPTH];
   logic [31:0]      target_mem [DEPTH];

   logic [PW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             mispredict_q, mispredict_d;
   logic             res_error_q, res_error_d;
   logic [31:0]      redirect_q, redirect_d;
   logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
   logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

   logic             push, pop, res_err, miss;
   logic [31:0]      head_pc, head_target, correct_pc;
   logic             head_taken;

   assign head_pc      = pc_mem[rd_ptr_q];
   assign head_taken   = taken_mem[rd_ptr_q];
   assign head_target  = target_mem[rd_ptr_q];
   assign pred_ready_o = (count_q < DEPTH_C);

   always_comb begin
      pop        = res_valid_i && (count_q != '0);
      res_err    = res_valid_i && (count_q == '0);
      correct_pc = res_taken_i ? res_target_i : head_pc + 32'd8;
      // Targets only matter when both predicted and actual are taken.
      miss       = pop && ((head_taken != res_taken_i) ||
                           (head_taken && res_taken_i && (head_target != res_target_i)));
      push       = pred_valid_i && pred_ready_o && !miss;

      rd_ptr_d   = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
      wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      count_d    = count_q;
      if (miss) begin
         rd_ptr_d = wr_ptr_q;
         count_d  = '0;
      end else if (push && !pop) begin
         count_d = count_q + CW'(1);
      end else if (pop && !push) begin
         count_d = count_q - CW'(1);
      end

      mispredict_d = miss;
      res_error_d  = res_err;
      redirect_d   = miss ? correct_pc : redirect_q;
      branch_cnt_d = (pop && (branch_cnt_q != '1)) ? branch_cnt_q + CNT_W'(1) : branch_cnt_q;
      miss_cnt_d   = (miss && (miss_cnt_q != '1)) ? miss_cnt_q + CNT_W'(1) : miss_cnt_q;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rd_ptr_q     <= '0;
         wr_ptr_q     <= '0;
         count_q      <= '0;
         mispredict_q <= 1'b0;
         res_error_q  <= 1'b0;
         redirect_q   <= '0;
         branch_cnt_q <= '0;
         miss_cnt_q   <= '0;
      end else begin
         rd_ptr_q     <= rd_ptr_d;
         wr_ptr_q     <= wr_ptr_d;
         count_q      <= count_d;
         mispredict_q <= mispredict_d;
         res_error_q  <= res_error_d;
         redirect_q   <= redirect_d;
         branch_cnt_q <= branch_cnt_d;
         miss_cnt_q   <= miss_cnt_d;
      end
   end

   // Entry storage carries no reset; only occupied slots are ever read.
   always_ff @(posedge clk_i) begin
      if (push) begin
         pc_mem[wr_ptr_q]     <= pred_pc_i;
         taken_mem[wr_ptr_q]  <= pred_taken_i;
         target_mem[wr_ptr_q] <= pred_target_i;
      end
   end

   assign mispredict_o  = mispredict_q;
   assign res_error_o   = res_error_q;
   assign redirect_pc_o = redirect_q;
   assign count_o       = count_q;
   assign branch_cnt_o  = branch_cnt_q;
   assign miss_cnt_o    = miss_cnt_q;

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver: push/resolve sequences with hand-computed
// expected flags, redirect PCs, occupancy and statistics.
module tb_branch_resolver;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        pred_valid_i, pred_taken_i, res_valid_i, res_taken_i;
   logic [31:0] pred_pc_i, pred_target_i, res_target_i;
   logic        pred_ready_o, mispredict_o, res_error_o;
   logic [31:0] redirect_pc_o;
   logic [2:0]  count_o;
   logic [31:0] branch_cnt_o, miss_cnt_o;

   int checks = 0;
   int errors = 0;

   branch_resolver #(.DEPTH(4), .CNT_W(32)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .pred_valid_i(pred_valid_i), .pred_ready_o(pred_ready_o),
      .pred_pc_i(pred_pc_i), .pred_taken_i(pred_taken_i), .pred_target_i(pred_target_i),
      .res_valid_i(res_valid_i), .res_taken_i(res_taken_i), .res_target_i(res_target_i),
      .mispredict_o(mispredict_o), .redirect_pc_o(redirect_pc_o), .res_error_o(res_error_o),
      .count_o(count_o), .branch_cnt_o(branch_cnt_o), .miss_cnt_o(miss_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      pred_valid_i = 0; pred_pc_i = '0; pred_taken_i = 0; pred_target_i = '0;
      res_valid_i = 0; res_taken_i = 0; res_target_i = '0;
   endtask

   task automatic set_push(input logic [31:0] pc, input logic tk, input logic [31:0] tg);
      pred_valid_i = 1; pred_pc_i = pc; pred_taken_i = tk; pred_target_i = tg;
   endtask

   task automatic set_res(input logic tk, input logic [31:0] tg);
      res_valid_i = 1; res_taken_i = tk; res_target_i = tg;
   endtask

   // Advance one clock; inputs return to idle just after the edge.
   task automatic tick();
      @(posedge clk_i); #1;
      $display("t=%0t cnt=%0d rdy=%0b mis=%0b redir=0x%0h err=%0b br=%0d miss=%0d",
               $time, count_o, pred_ready_o, mispredict_o, redirect_pc_o, res_error_o,
               branch_cnt_o, miss_cnt_o);
      idle();
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_count"}, 32'(count_o), 0);
      chk({tag, "_ready"}, 32'(pred_ready_o), 1);
      chk({tag, "_mis"},   32'(mispredict_o), 0);
      chk({tag, "_err"},   32'(res_error_o), 0);
      chk({tag, "_redir"}, redirect_pc_o, 0);
      chk({tag, "_br"},    branch_cnt_o, 0);
      chk({tag, "_miss"},  miss_cnt_o, 0);
   endtask

   initial begin
      idle();
      rst_i = 1;
      #2;
      chk_reset("reset");
      @(posedge clk_i); #1;
      rst_i = 0;

      // Correct taken prediction
      set_push(32'h100, 1, 32'h80); tick();
      chk("t1_count_after_push", 32'(count_o), 1);
      set_res(1, 32'h80); tick();
      chk("t1_mis", 32'(mispredict_o), 0);
      chk("t1_br", branch_cnt_o, 1);
      chk("t1_miss", miss_cnt_o, 0);
      chk("t1_count", 32'(count_o), 0);

      // Direction mispredict flushes the younger entry
      set_push(32'h200, 0, 32'h0); tick();
      set_push(32'h300, 1, 32'h400); tick();
      chk("t2_count_pre", 32'(count_o), 2);
      set_res(1, 32'h240); tick();
      chk("t2_mis", 32'(mispredict_o), 1);
      chk("t2_redir", redirect_pc_o, 32'h240);
      chk("t2_count", 32'(count_o), 0);
      chk("t2_miss", miss_cnt_o, 1);
      chk("t2_br", branch_cnt_o, 2);
      tick();
      chk("t2_mis_drop", 32'(mispredict_o), 0);
      chk("t2_redir_hold", redirect_pc_o, 32'h240);

      // Predicted taken, actually not taken: fall-through pc+8
      set_push(32'h500, 1, 32'h600); tick();
      set_res(0, 32'h0); tick();
      chk("t3_mis", 32'(mispredict_o), 1);
      chk("t3_redir", redirect_pc_o, 32'h508);
      tick();
      chk("t3_mis_one_cycle", 32'(mispredict_o), 0);
      chk("t3_redir_hold", redirect_pc_o, 32'h508);
      chk("t3_miss", miss_cnt_o, 2);

      // Fill to full; resolve with a push in the same cycle drops the push
      for (int i = 0; i < 4; i++) begin
         set_push(32'h1000 + 32'(i) * 32'h10, 0, 32'h0); tick();
      end
      chk("t4_count_full", 32'(count_o), 4);
      chk("t4_ready_full", 32'(pred_ready_o), 0);
      set_push(32'h2000, 0, 32'h0); set_res(0, 32'hDEAD);
      chk("t4_ready_with_pop", 32'(pred_ready_o), 0);
      tick();
      chk("t4_count_after_pop", 32'(count_o), 3);
      chk("t4_mis_nt_nt", 32'(mispredict_o), 0);
      chk("t4_br", branch_cnt_o, 4);
      set_push(32'h2000, 0, 32'h0); tick();
      chk("t4_count_refill", 32'(count_o), 4);
      for (int i = 0; i < 4; i++) begin
         set_res(0, 32'hBEEF); tick();
         chk("t4_drain_mis", 32'(mispredict_o), 0);
      end
      chk("t4_count_drained", 32'(count_o), 0);
      chk("t4_br_drained", branch_cnt_o, 8);

      // Taken/taken with wrong target
      set_push(32'h800, 1, 32'h900); tick();
      set_res(1, 32'h904); tick();
      chk("t5_mis", 32'(mispredict_o), 1);
      chk("t5_redir", redirect_pc_o, 32'h904);
      chk("t5_miss", miss_cnt_o, 3);
      chk("t5_br", branch_cnt_o, 9);

      // Resolve on empty queue with simultaneous push
      set_push(32'h700, 0, 32'h0); set_res(0, 32'h0); tick();
      chk("t6_err", 32'(res_error_o), 1);
      chk("t6_count", 32'(count_o), 1);
      chk("t6_br", branch_cnt_o, 9);
      chk("t6_mis", 32'(mispredict_o), 0);
      chk("t6_miss", miss_cnt_o, 3);
      chk("t6_redir_hold", redirect_pc_o, 32'h904);
      tick();
      chk("t6_err_pulse", 32'(res_error_o), 0);

      // Mispredict drops a same-cycle push
      set_push(32'hA00, 0, 32'h0); set_res(1, 32'h7777); tick();
      chk("t7_mis", 32'(mispredict_o), 1);
      chk("t7_count", 32'(count_o), 0);
      chk("t7_redir", redirect_pc_o, 32'h7777);
      chk("t7_br", branch_cnt_o, 10);

      // Asynchronous reset mid-operation with a pulse pending
      set_push(32'hB00, 1, 32'hC00); tick();
      set_push(32'hB10, 0, 32'h0); tick();
      set_push(32'hB20, 0, 32'h0); tick();
      chk("t8_count_pre", 32'(count_o), 3);
      set_res(0, 32'h0); tick();
      chk("t8_mis_pending", 32'(mispredict_o), 1);
      #2;
      rst_i = 1;
      #1;
      chk_reset("t8_async");
      @(posedge clk_i); #2;
      rst_i = 0;
      tick();
      chk("t8_no_mis_after", 32'(mispredict_o), 0);
      chk("t8_no_err_after", 32'(res_error_o), 0);
      chk("t8_count_after", 32'(count_o), 0);
      set_res(0, 32'h0); tick();
      chk("t8_empty_err", 32'(res_error_o), 1);
      chk("t8_br_unchanged", branch_cnt_o, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/branch_resolver.md
BRANCH_RESOLVER -- requirements
Module: branch_resolver

Interface
REQ-001 SHALL have parameter DEPTH, default 4, in-flight prediction queue entries (power of two, 2..16).
REQ-002 SHALL have parameter CNT_W, default 32, width of statistics counters.
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 clk_i  input  1  sole clock, all state updates on rising edge.
REQ-005 rst_i  input  1  asynchronous active-high reset.
REQ-006 pred_valid_i  input  1  fetch presents a prediction this cycle.
REQ-007 pred_ready_o  output  1  queue accepts a prediction this cycle.
REQ-008 pred_pc_i  input  32  PC of the predicted branch.
REQ-009 pred_taken_i  input  1  predicted direction.
REQ-010 pred_target_i  input  32  predicted target; meaningful only when pred_taken_i=1.
REQ-011 res_valid_i  input  1  execute resolves the oldest outstanding branch this cycle.
REQ-012 res_taken_i  input  1  actual direction.
REQ-013 res_target_i  input  32  actual target; meaningful only when res_taken_i=1.
REQ-014 mispredict_o  output  1  registered one-cycle pulse, prediction was wrong.
REQ-015 redirect_pc_o  output  32  registered correct next-fetch PC, valid while mispredict_o=1.
REQ-016 res_error_o  output  1  registered one-cycle pulse, resolve arrived with queue empty.
REQ-017 count_o  output  $clog2(DEPTH)+1  current queue occupancy.
REQ-018 branch_cnt_o  output  CNT_W  resolved branches since reset.
REQ-019 miss_cnt_o  output  CNT_W  mispredicted branches since reset.

Function
REQ-020 SHALL hold predictions in an in-order FIFO of DEPTH entries {pc, taken, target}; head = oldest.
REQ-021 pred_ready_o SHALL be combinational: 1 iff count_o < DEPTH; push occurs iff pred_valid_i && pred_ready_o.
REQ-022 When full, pred_ready_o SHALL be 0 even if a resolve pops in the same cycle (no pass-through).
REQ-023 Resolve with count_o>0 SHALL pop the head and compare in the same cycle.
REQ-024 Correct next PC SHALL be res_target_i if res_taken_i=1, else head.pc+8 (branch plus delay slot), 32-bit wrap-around.
REQ-025 Mispredict SHALL be: head.taken != res_taken_i, or both taken and head.target != res_target_i; not-taken/not-taken never compares targets.
REQ-026 mispredict_o and redirect_pc_o SHALL update one cycle after the resolve edge (latency 1); mispredict_o is 0 in every cycle not following a mispredicting resolve.
REQ-027 redirect_pc_o SHALL hold its last value when mispredict_o=0.
REQ-028 On a mispredicting resolve, all remaining entries SHALL be discarded (count_o=0 next cycle), and any push in that same cycle SHALL be dropped.
REQ-029 On a correct resolve with a simultaneous push, count_o SHALL be unchanged and the new entry appended at tail.
REQ-030 Resolve with count_o=0 SHALL pulse res_error_o next cycle, SHALL NOT change counters or mispredict_o, and a simultaneous push SHALL still occur.
REQ-031 branch_cnt_o SHALL increment per non-error resolve; miss_cnt_o per mispredict; both saturate at all-ones.
REQ-032 Read/write pointers SHALL wrap modulo DEPTH; full/empty distinguished by count, not pointer equality.

Reset
REQ-033 rst_i=1 SHALL immediately, without clock, force count_o=0, pred_ready_o=1, mispredict_o=0, res_error_o=0, redirect_pc_o=0, branch_cnt_o=0, miss_cnt_o=0.
REQ-034 Reset asserted mid-operation SHALL discard all queued entries; no pulse output SHALL appear on the first edge after deassertion.
REQ-035 Queue entry storage need not be reset; no output SHALL depend on unwritten entries.

Verification
REQ-036 Push {pc=0x100,taken=1,tgt=0x80}; resolve taken tgt=0x80 -> mispredict_o stays 0, branch_cnt_o=1, miss_cnt_o=0, count_o=0.
REQ-037 Push {0x200,taken=0}, push {0x300,taken=1,0x400}; resolve taken tgt=0x240 -> next cycle mispredict_o=1, redirect_pc_o=0x240, count_o=0, miss_cnt_o=1.
REQ-038 Push {0x500,taken=1,0x600}; resolve not-taken -> redirect_pc_o=0x508, mispredict_o=1 for exactly one cycle.
REQ-039 Fill 4 entries -> pred_ready_o=0; resolve correct with pred_valid_i=1 same cycle -> push dropped, count_o=3; next cycle push accepted, count_o=4.
REQ-040 Resolve with queue empty plus push {0x700,0} same cycle -> res_error_o pulse, count_o=1, branch_cnt_o unchanged.
REQ-041 Assert rst_i asynchronously with 3 entries queued and a mispredict pending -> all outputs reset values before next edge; no pulse after release.
